// File: rtl/lcd_spi_write.sv
// rtl/lcd_spi_write.sv - 9-bit command/data word to 4-wire SPI (mode 0) write engine for the LCD panel
module lcd_spi_write #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [8:0] wr_data,
    input  logic       en_write,
    output logic       wr_done,
    output logic       busy,
    output logic       wr_err,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       lcd_cs,
    output logic       lcd_dc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state;
    logic       en_write_d;
    logic       req;
    logic [7:0] hp_cnt;
    logic [4:0] hp_idx;
    logic [4:0] idx_next;
    logic       hp_end;
    // Bits 6:0 of the payload still to be shifted; bit 7 goes straight to MOSI at CS assertion.
    logic [6:0] shreg;

    assign req      = en_write & ~en_write_d;
    assign hp_end   = (hp_cnt == DIV_LAST);
    assign idx_next = hp_idx + 5'd1;

    // Transfer sequencer: edge-detects the request, paces half-periods and drives the SPI pins.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            en_write_d <= 1'b0;
            hp_cnt     <= 8'd0;
            hp_idx     <= 5'd0;
            shreg      <= 7'd0;
            wr_done    <= 1'b0;
            wr_err     <= 1'b0;
            busy       <= 1'b0;
            lcd_sclk   <= 1'b0;
            lcd_mosi   <= 1'b0;
            lcd_cs     <= 1'b1;
            lcd_dc     <= 1'b0;
        end else begin
            en_write_d <= en_write;
            wr_done    <= 1'b0;
            wr_err     <= req && (state != IDLE);

            case (state)
                IDLE: begin
                    if (req) begin
                        state    <= SHIFT;
                        shreg    <= wr_data[6:0];
                        lcd_dc   <= wr_data[8];
                        lcd_mosi <= wr_data[7];
                        lcd_cs   <= 1'b0;
                        lcd_sclk <= 1'b0;
                        busy     <= 1'b1;
                        hp_cnt   <= 8'd0;
                        hp_idx   <= 5'd0;
                    end
                end

                SHIFT: begin
                    if (hp_end) begin
                        hp_cnt <= 8'd0;
                        hp_idx <= idx_next;
                        if (idx_next[0]) begin
                            lcd_sclk <= 1'b1;
                        end else begin
                            lcd_sclk <= 1'b0;
                            // After the 8th falling edge bit 0 stays on MOSI through the hold.
                            if (idx_next == 5'd16) begin
                                state <= HOLD;
                            end else begin
                                lcd_mosi <= shreg[6];
                                shreg    <= {shreg[5:0], 1'b0};
                            end
                        end
                    end else begin
                        hp_cnt <= hp_cnt + 8'd1;
                    end
                end

                HOLD: begin
                    if (hp_end) begin
                        state    <= IDLE;
                        hp_cnt   <= 8'd0;
                        hp_idx   <= idx_next;
                        lcd_cs   <= 1'b1;
                        lcd_mosi <= 1'b0;
                        wr_done  <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        hp_cnt <= hp_cnt + 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
